dual_issue_scoreboard: RTL and testbench

- Issue controller in front of the two-write-port 128x128 register file.
- Each cycle receives one even-pipe and one odd-pipe decoded instruction. Decides dual-issue, single-issue or stall from RAW/WAW hazards against in-flight results.
- Tracks every pending register write with a per-register latency countdown. Instructions are only granted when their operands will be read correctly from the register file.

---
 rtl/spu_pkg.sv | 27 ++
 rtl/dual_issue_scoreboard_if.sv | 36 +++
 rtl/sb_hazard_check.sv | 17 +
 rtl/dual_issue_scoreboard.sv | 73 +++++++
 tb/tb_dual_issue_scoreboard.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared types and constants for the dual-issue scoreboard
package spu_pkg;
    localparam int NUM_REGS = 128;
    localparam int ADDR_W   = 7;
    localparam int LAT_W    = 4;
    localparam int PERF_W   = 32;

    typedef logic [0:ADDR_W-1] reg_addr_t;
    typedef logic [0:LAT_W-1]  lat_t;

    typedef struct packed {
        logic       valid;
        reg_addr_t  ra;
        reg_addr_t  rb;
        reg_addr_t  rc;
        logic [0:2] src_use;
        reg_addr_t  rt;
        logic       wr;
        lat_t       lat;
    } issue_req_t;

    function automatic logic reads_reg(issue_req_t q, reg_addr_t r);
        return (q.src_use[0] && q.ra == r) ||
               (q.src_use[1] && q.rb == r) ||
               (q.src_use[2] && q.rc == r);
    endfunction
endpackage

// File: rtl/dual_issue_scoreboard_if.sv
// rtl/dual_issue_scoreboard_if.sv - even/odd issue request and grant bundle
interface dual_issue_scoreboard_if;
    import spu_pkg::*;

    logic       ep_valid;
    reg_addr_t  ep_ra;
    reg_addr_t  ep_rb;
    reg_addr_t  ep_rc;
    logic [0:2] ep_use;
    reg_addr_t  ep_rt;
    logic       ep_wr;
    lat_t       ep_lat;
    logic       op_valid;
    reg_addr_t  op_ra;
    reg_addr_t  op_rb;
    logic [0:1] op_use;
    reg_addr_t  op_rt;
    logic       op_wr;
    lat_t       op_lat;
    logic       op_first;
    logic       ep_issue;
    logic       op_issue;
    logic       stall;

    modport master (
        output ep_valid, ep_ra, ep_rb, ep_rc, ep_use, ep_rt, ep_wr, ep_lat,
        output op_valid, op_ra, op_rb, op_use, op_rt, op_wr, op_lat, op_first,
        input  ep_issue, op_issue, stall
    );

    modport slave (
        input  ep_valid, ep_ra, ep_rb, ep_rc, ep_use, ep_rt, ep_wr, ep_lat,
        input  op_valid, op_ra, op_rb, op_use, op_rt, op_wr, op_lat, op_first,
        output ep_issue, op_issue, stall
    );
endinterface

// File: rtl/sb_hazard_check.sv
// rtl/sb_hazard_check.sv - RAW/WAW hazard detection for one instruction
module sb_hazard_check
    import spu_pkg::*;
(
    input  issue_req_t req,
    input  lat_t       cnt [NUM_REGS],
    output logic       raw_haz,
    output logic       waw_haz,
    output logic       tracks
);
    assign raw_haz = (req.src_use[0] && cnt[req.ra] != '0) ||
                     (req.src_use[1] && cnt[req.rb] != '0) ||
                     (req.src_use[2] && cnt[req.rc] != '0);
    assign waw_haz = req.wr && cnt[req.rt] != '0;
    // a zero-latency write is bypassed elsewhere and never enters the scoreboard
    assign tracks  = req.valid && req.wr && req.lat != '0;
endmodule

// File: rtl/dual_issue_scoreboard.sv
// rtl/dual_issue_scoreboard.sv - dual-issue grant logic with per-register latency countdown
module dual_issue_scoreboard
    import spu_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    dual_issue_scoreboard_if.slave   bus,
    output logic [0:NUM_REGS-1]      busy_vec,
    output logic [0:PERF_W-1]        dual_cnt,
    output logic [0:PERF_W-1]        stall_cnt
);
    lat_t       cnt [NUM_REGS];
    issue_req_t req_e, req_o, old_q, young_q;
    logic       raw_e, waw_e, trk_e, raw_o, waw_o, trk_o;
    logic       old_haz, young_haz, intra_blk, old_gnt, young_gnt;

    assign req_e = '{valid: bus.ep_valid, ra: bus.ep_ra, rb: bus.ep_rb, rc: bus.ep_rc,
                     src_use: bus.ep_use, rt: bus.ep_rt, wr: bus.ep_wr, lat: bus.ep_lat};
    assign req_o = '{valid: bus.op_valid, ra: bus.op_ra, rb: bus.op_rb, rc: '0,
                     src_use: {bus.op_use, 1'b0}, rt: bus.op_rt, wr: bus.op_wr, lat: bus.op_lat};

    sb_hazard_check u_haz_e (.req(req_e), .cnt(cnt), .raw_haz(raw_e), .waw_haz(waw_e), .tracks(trk_e));
    sb_hazard_check u_haz_o (.req(req_o), .cnt(cnt), .raw_haz(raw_o), .waw_haz(waw_o), .tracks(trk_o));

    always_comb begin
        old_q     = bus.op_first ? req_o : req_e;
        young_q   = bus.op_first ? req_e : req_o;
        old_haz   = bus.op_first ? (raw_o || waw_o) : (raw_e || waw_e);
        young_haz = bus.op_first ? (raw_e || waw_e) : (raw_o || waw_o);
        // the younger may not read or overwrite what the older of the pair produces
        intra_blk = old_q.valid && old_q.wr &&
                    (reads_reg(young_q, old_q.rt) || (young_q.wr && young_q.rt == old_q.rt));
        old_gnt   = !reset && old_q.valid && !old_haz;
        young_gnt = !reset && young_q.valid && !young_haz && !intra_blk &&
                    (old_gnt || !old_q.valid);
        bus.ep_issue = bus.op_first ? young_gnt : old_gnt;
        bus.op_issue = bus.op_first ? old_gnt : young_gnt;
        bus.stall    = !reset && ((bus.ep_valid && !bus.ep_issue) ||
                                  (bus.op_valid && !bus.op_issue));
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) busy_vec[r] = (cnt[r] != '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (bus.ep_issue && trk_e && req_e.rt == reg_addr_t'(r))
                    cnt[r] <= req_e.lat;
                else if (bus.op_issue && trk_o && req_o.rt == reg_addr_t'(r))
                    cnt[r] <= req_o.lat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - lat_t'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dual_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (bus.ep_issue && bus.op_issue && dual_cnt != '1)
                dual_cnt <= dual_cnt + PERF_W'(1);
            if (bus.stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb/tb_dual_issue_scoreboard.sv - directed self-checking bench for dual_issue_scoreboard
module tb_dual_issue_scoreboard;
    logic         clock;
    logic         reset;
    logic [0:127] busy_vec;
    logic [0:31]  dual_cnt;
    logic [0:31]  stall_cnt;
    int           tests;
    int           fails;

    dual_issue_scoreboard_if bus ();

    dual_issue_scoreboard dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .busy_vec  (busy_vec),
        .dual_cnt  (dual_cnt),
        .stall_cnt (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.ep_valid = 0; bus.ep_ra = 0; bus.ep_rb = 0; bus.ep_rc = 0; bus.ep_use = 0;
        bus.ep_rt = 0; bus.ep_wr = 0; bus.ep_lat = 0;
        bus.op_valid = 0; bus.op_ra = 0; bus.op_rb = 0; bus.op_use = 0;
        bus.op_rt = 0; bus.op_wr = 0; bus.op_lat = 0; bus.op_first = 0;
    endtask

    task automatic set_ep(input int rt, input int lat, input logic wr,
                          input int ra, input int rb, input int rc, input logic [2:0] use_bits);
        bus.ep_valid = 1; bus.ep_rt = 7'(rt); bus.ep_lat = 4'(lat); bus.ep_wr = wr;
        bus.ep_ra = 7'(ra); bus.ep_rb = 7'(rb); bus.ep_rc = 7'(rc); bus.ep_use = use_bits;
    endtask

    task automatic set_op(input int rt, input int lat, input logic wr,
                          input int ra, input int rb, input logic [1:0] use_bits);
        bus.op_valid = 1; bus.op_rt = 7'(rt); bus.op_lat = 4'(lat); bus.op_wr = wr;
        bus.op_ra = 7'(ra); bus.op_rb = 7'(rb); bus.op_use = use_bits;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1;
        idle();
        set_ep(1, 2, 1, 0, 0, 0, 3'b000);
        #2;
        chk("rst_ep_issue", bus.ep_issue, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_busy", {31'b0, |busy_vec}, 0);
        chk("rst_dual_cnt", dual_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        repeat (2) @(posedge clock);
        #1 reset = 0;
        idle();
        #1;
        chk("idle_grants", {30'b0, bus.ep_issue, bus.op_issue}, 0);
        chk("idle_stall", bus.stall, 0);

        // independent pair
        tick();
        set_ep(5, 6, 1, 0, 0, 0, 3'b000);
        set_op(9, 4, 1, 0, 0, 2'b00);
        #1;
        chk("pair_ep_issue", bus.ep_issue, 1);
        chk("pair_op_issue", bus.op_issue, 1);
        chk("pair_stall", bus.stall, 0);
        tick();
        idle();
        #1;
        chk("pair_dual_cnt", dual_cnt, 1);
        chk("pair_busy5", busy_vec[5], 1);
        chk("pair_busy9", busy_vec[9], 1);
        repeat (3) tick();
        chk("pair_busy9_last", busy_vec[9], 1);
        tick();
        chk("pair_busy9_clear", busy_vec[9], 0);
        chk("pair_busy5_hold", busy_vec[5], 1);
        repeat (2) tick();
        chk("pair_busy5_clear", busy_vec[5], 0);
        chk("pair_all_clear", {31'b0, |busy_vec}, 0);

        // RAW against an in-flight result
        tick();
        set_ep(3, 2, 1, 0, 0, 0, 3'b000);
        #1;
        chk("raw_producer", bus.ep_issue, 1);
        tick();
        idle();
        tick();
        set_op(0, 0, 0, 3, 0, 2'b10);
        #1;
        chk("raw_op_blocked", bus.op_issue, 0);
        chk("raw_stall", bus.stall, 1);
        tick();
        chk("raw_op_granted", bus.op_issue, 1);
        chk("raw_stall_clear", bus.stall, 0);
        chk("raw_stall_cnt", stall_cnt, 1);

        // intra-pair dependency, even older
        tick();
        idle();
        set_ep(7, 2, 1, 0, 0, 0, 3'b000);
        set_op(0, 0, 0, 0, 7, 2'b01);
        #1;
        chk("intra_ep_issue", bus.ep_issue, 1);
        chk("intra_op_blocked", bus.op_issue, 0);
        tick();
        bus.ep_valid = 0;
        #1;
        chk("intra_op_wait1", bus.op_issue, 0);
        tick();
        chk("intra_op_wait2", bus.op_issue, 0);
        tick();
        chk("intra_op_granted", bus.op_issue, 1);
        chk("intra_stall_cnt", stall_cnt, 4);

        // older odd blocked holds back the younger even
        tick();
        idle();
        set_ep(12, 3, 1, 0, 0, 0, 3'b000);
        #1;
        chk("order_producer", bus.ep_issue, 1);
        tick();
        idle();
        bus.op_first = 1;
        set_op(0, 0, 0, 12, 0, 2'b10);
        set_ep(13, 1, 1, 0, 0, 0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("order_blocked", {30'b0, bus.ep_issue, bus.op_issue}, 0);
            tick();
        end
        #1;
        chk("order_released", {30'b0, bus.ep_issue, bus.op_issue}, 3);
        tick();
        idle();
        #1;
        chk("order_dual_cnt", dual_cnt, 2);
        chk("order_stall_cnt", stall_cnt, 7);
        chk("order_busy13", busy_vec[13], 1);

        // WAW hold, then lat=0 write bypasses the scoreboard
        set_ep(20, 2, 1, 0, 0, 0, 3'b000);
        #1;
        chk("waw_first", bus.ep_issue, 1);
        tick();
        set_ep(20, 5, 1, 0, 0, 0, 3'b000);
        #1;
        chk("waw_hold1", bus.ep_issue, 0);
        tick();
        chk("waw_hold2", bus.ep_issue, 0);
        tick();
        set_op(21, 0, 1, 0, 0, 2'b00);
        #1;
        chk("waw_granted", {30'b0, bus.ep_issue, bus.op_issue}, 3);
        tick();
        idle();
        #1;
        chk("waw_busy20", busy_vec[20], 1);
        chk("lat0_busy21", busy_vec[21], 0);
        chk("waw_dual_cnt", dual_cnt, 3);
        chk("waw_stall_cnt", stall_cnt, 9);
        repeat (4) tick();
        chk("waw_busy20_cnt5", busy_vec[20], 1);
        tick();
        chk("waw_busy20_clear", busy_vec[20], 0);

        // asynchronous reset mid-flight
        set_ep(40, 9, 1, 0, 0, 0, 3'b000);
        #1;
        chk("mid_producer", bus.ep_issue, 1);
        tick();
        idle();
        #1;
        chk("mid_busy40", busy_vec[40], 1);
        #2 reset = 1;
        #1;
        chk("mid_busy_clear", {31'b0, |busy_vec}, 0);
        chk("mid_dual_cnt", dual_cnt, 0);
        chk("mid_stall_cnt", stall_cnt, 0);
        set_op(0, 0, 0, 40, 0, 2'b10);
        set_ep(41, 3, 1, 0, 0, 0, 3'b000);
        #1;
        chk("mid_grants", {30'b0, bus.ep_issue, bus.op_issue}, 0);
        chk("mid_stall", bus.stall, 0);
        tick();
        chk("mid_grants_edge", {30'b0, bus.ep_issue, bus.op_issue}, 0);
        reset = 0;
        idle();
        tick();
        set_op(0, 0, 0, 40, 0, 2'b10);
        #1;
        chk("post_reset_reader", bus.op_issue, 1);
        chk("post_reset_stall", bus.stall, 0);
        tick();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
